apb_rr_master: RTL and testbench

- Multi-requester APB master that shares one APB bus between NUM_REQ internal requesters.
- Arbitrates round-robin, sequences SETUP/ACCESS phases, returns read data and completion status to the winning requester.
- Enforces an ACCESS-phase timeout.
- Sits between block-level command sources (DMA, CPU bridge, config sequencer) and the APB slave fabric.

---
 rtl/apb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/apb_rr_master.sv | 198 +++++++++++++++++++
 tb/tb_apb_rr_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus-phase state encoding (kept identical to the
// existing APB master so waveforms and debug scripts read the same) and
// transfer direction constants.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10
   } apb_state_e;

   localparam logic DIR_WRITE = 1'b1;
   localparam logic DIR_READ  = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req   : request vector
//   ptr   : index of the previous winner; search starts at ptr+1 (mod N)
//   gnt   : one-hot winner (zero when nothing is requested)
//   valid : at least one request present
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          valid
);

   int unsigned idx;

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!valid && req[idx]) begin
            gnt[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_rr_master.sv
// Multi-requester APB master. NUM_REQ command sources share one APB bus
// through a round-robin arbiter; the winner's command is latched, driven
// through SETUP/ACCESS, and the completion (done/err, read data) is returned
// to it. ACCESS is forcibly terminated after TIMEOUT cycles without pready.
//
// Ports:
//   pclk, presetn          clock, async active-low reset
//   req/req_write          per-requester request and direction
//   req_addr/req_wdata     packed per-requester address / write data
//   gnt, done              one-hot single-cycle accept / finish pulses
//   rdata, err             last read data (held), error flag valid with done
//   psel..pwdata           APB master outputs
//   prdata, pready, pslverr APB slave responses
//
// state  | meaning
// IDLE   | bus idle, arbitrating every cycle
// SETUP  | psel=1, penable=0, gnt pulse to the new owner
// ACCESS | psel=1, penable=1, waiting for pready or timeout
module apb_rr_master
   import apb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    done,
   output logic [DW-1:0]         rdata,
   output logic                  err,
   output logic                  psel,
   output logic                  penable,
   output logic [AW-1:0]         paddr,
   output logic                  pwrite,
   output logic [DW-1:0]         pwdata,
   input  logic [DW-1:0]         prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

   apb_state_e           state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   owner_q, owner_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [DW-1:0]        rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic                 psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic [AW-1:0]        paddr_q, paddr_d;
   logic                 pwrite_q, pwrite_d;
   logic [DW-1:0]        pwdata_q, pwdata_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;

   logic [NUM_REQ-1:0]   arb_gnt;
   logic                 arb_valid;
   logic [PW-1:0]        win_idx;
   logic [AW-1:0]        win_addr;
   logic                 win_write;
   logic [DW-1:0]        win_wdata;
   logic                 complete;
   logic                 launch;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_arb (
      .req   (req),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .valid (arb_valid)
   );

   // Winner's command fields, selected by the one-hot grant.
   always_comb begin
      win_idx   = '0;
      win_addr  = '0;
      win_write = 1'b0;
      win_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            win_idx   = PW'(i);
            win_addr  = req_addr[i*AW +: AW];
            win_write = req_write[i];
            win_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      gnt_d     = '0;
      done_d    = '0;
      rdata_d   = rdata_q;
      err_d     = 1'b0;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      tcnt_d    = tcnt_q;
      complete  = 1'b0;
      launch    = 1'b0;

      case (state_q)
         ST_IDLE: launch = arb_valid;
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (pready) begin
               complete = 1'b1;
               err_d    = pslverr;
               if (pwrite_q == DIR_READ) rdata_d = prdata;
            end else if (tcnt_q == TCNT_LAST) begin
               complete = 1'b1;
               err_d    = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Completion re-arbitrates in the same cycle so a pending requester
      // goes straight to SETUP; its gnt lines up with the old owner's done.
      if (complete) begin
         done_d  = owner_q;
         tcnt_d  = '0;
         state_d = ST_IDLE;
         launch  = arb_valid;
      end

      if (launch) begin
         state_d  = ST_SETUP;
         gnt_d    = arb_gnt;
         owner_d  = arb_gnt;
         ptr_d    = win_idx;
         paddr_d  = win_addr;
         pwrite_d = win_write;
         pwdata_d = win_wdata;
      end

      psel_d    = (state_d != ST_IDLE);
      penable_d = (state_d == ST_ACCESS);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= ST_IDLE;
         ptr_q     <= PW'(NUM_REQ - 1);
         owner_q   <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign rdata   = rdata_q;
   assign err     = err_q;
   assign psel    = psel_q;
   assign penable = penable_q;
   assign paddr   = paddr_q;
   assign pwrite  = pwrite_q;
   assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed latency / reset cases plus a randomized
// phase where requesters issue bursts and a memory-backed slave answers with
// random wait states, errors and stalls. Expected completions are queued at
// grant time by a reference model and checked by an independent done monitor.
module tb_apb_rr_master;
   import apb_pkg::*;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic            pclk = 1'b0;
   logic            presetn;
   logic [N-1:0]    req, req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt, done;
   logic [DW-1:0]   rdata, prdata, pwdata;
   logic [AW-1:0]   paddr;
   logic            err, psel, penable, pwrite, pready, pslverr;

   always #5 pclk = ~pclk;

   apb_rr_master #(.NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
      .rdata(rdata), .err(err), .psel(psel), .penable(penable), .paddr(paddr),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr)
   );

   typedef struct {
      int            owner;
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic          wr;
      logic [DW-1:0] wdata;
      int            waits;   // >= TO means the slave never answers
      logic          slverr;
   } plan_t;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t          exp_q[$];
   plan_t         plan_q[$];
   exp_t          mon_e;
   plan_t         cur;
   logic [DW-1:0] ref_mem[16];
   logic [DW-1:0] slv_mem[16];
   logic [DW-1:0] ref_rdata;
   int            ref_ptr;
   int            cmd_left[N];
   bit            rnd_on = 1'b0;
   bit            prev_idle = 1'b1;
   bit            in_acc = 1'b0;
   int            acc_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Rotating priority: first requester after the last winner, wrapping.
   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic new_cmd(input int i);
      req[i]                = 1'b1;
      req_write[i]          = 1'($urandom_range(0, 1));
      req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15) * 4);
      req_wdata[i*DW +: DW] = $urandom;
   endtask

   task automatic stim_step();
      int    w;
      int    idx;
      plan_t p;
      exp_t  e;
      logic  exp_g;
      // Arbitration happens after an IDLE cycle or a completing ACCESS cycle.
      exp_g = (prev_idle || done != '0) && (req != '0);
      check("gnt_present", 64'(gnt != '0), 64'(exp_g));
      if (gnt != '0) begin
         w = rr_pick(req, ref_ptr);
         check("gnt_winner", 64'(gnt), (w < 0) ? 64'd0 : (64'd1 << w));
         if (w >= 0) begin
            ref_ptr  = w;
            p.addr   = req_addr[w*AW +: AW];
            p.wr     = req_write[w];
            p.wdata  = req_wdata[w*DW +: DW];
            p.waits  = ($urandom_range(0, 7) == 0) ? TO + 4 : int'($urandom_range(0, 3));
            p.slverr = ($urandom_range(0, 4) == 0);
            plan_q.push_back(p);
            idx     = int'(p.addr[5:2]);
            e.owner = w;
            e.err   = (p.waits >= TO) || p.slverr;
            if (p.waits < TO) begin
               if (p.wr == DIR_READ) ref_rdata = ref_mem[idx];
               else if (!p.slverr) ref_mem[idx] = p.wdata;
            end
            e.rdata = ref_rdata;
            exp_q.push_back(e);
            cmd_left[w]--;
            if (cmd_left[w] > 0) new_cmd(w);
            else req[w] = 1'b0;
         end
      end

      // Slave
      if (psel && penable) begin
         if (!in_acc) begin
            in_acc  = 1'b1;
            acc_cnt = 0;
            if (plan_q.size() == 0) begin
               check("access_unexpected", 64'd1, 64'd0);
               cur.addr = paddr; cur.wr = pwrite; cur.wdata = pwdata;
               cur.waits = 0; cur.slverr = 1'b0;
            end else begin
               cur = plan_q.pop_front();
            end
            check("pwrite", 64'(pwrite), 64'(cur.wr));
            if (cur.wr) check("pwdata", 64'(pwdata), 64'(cur.wdata));
         end
         acc_cnt++;
         check("paddr", 64'(paddr), 64'(cur.addr));
         if (cur.waits < TO && acc_cnt == cur.waits + 1) begin
            pready  = 1'b1;
            pslverr = cur.slverr;
            prdata  = cur.wr ? $urandom : slv_mem[cur.addr[5:2]];
            if (cur.wr && !cur.slverr) slv_mem[cur.addr[5:2]] = pwdata;
         end else begin
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
         end
      end else begin
         if (in_acc) begin
            check("access_len", 64'(acc_cnt), 64'((cur.waits < TO) ? cur.waits + 1 : TO));
            in_acc = 1'b0;
         end
         pready  = 1'($urandom_range(0, 1));
         pslverr = 1'($urandom_range(0, 1));
         prdata  = $urandom;
      end

      // Requesters: start bursts, occasionally withdraw an ungranted request.
      for (int i = 0; i < N; i++) begin
         if (!req[i] && cmd_left[i] == 0 && rnd_on && $urandom_range(0, 5) == 0) begin
            cmd_left[i] = int'($urandom_range(1, 3));
            new_cmd(i);
         end else if (req[i] && !gnt[i] && $urandom_range(0, 40) == 0) begin
            req[i]      = 1'b0;
            cmd_left[i] = 0;
         end
      end
      prev_idle = !psel;
   endtask

   // Done monitor: every completion must match the oldest queued expectation.
   always @(negedge pclk) begin
      if (presetn && done != '0) begin
         check("done_onehot", 64'($countones(done)), 64'd1);
         if (exp_q.size() == 0) begin
            check("done_unexpected", 64'(done), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("done_owner", 64'(done), 64'd1 << mon_e.owner);
            check("done_err", 64'(err), 64'(mon_e.err));
            check("done_rdata", 64'(rdata), 64'(mon_e.rdata));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      exp_t e;
      bit   drained;
      presetn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      for (int k = 0; k < 16; k++) begin
         ref_mem[k] = $urandom;
         slv_mem[k] = ref_mem[k];
      end
      for (int i = 0; i < N; i++) cmd_left[i] = 0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("rst_psel", 64'(psel), 64'd0);
      check("rst_penable", 64'(penable), 64'd0);
      check("rst_gnt_done", 64'({gnt, done}), 64'd0);
      check("rst_err_pwrite", 64'({err, pwrite}), 64'd0);
      check("rst_paddr", 64'(paddr), 64'd0);
      check("rst_pwdata", 64'(pwdata), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      presetn = 1'b1;

      // Single zero-wait read: gnt/psel in cycle 1, penable in 2, done in 3.
      @(negedge pclk);
      req[0] = 1'b1; req_write[0] = DIR_READ; req_addr[0 +: AW] = 32'h40;
      @(negedge pclk);
      check("rd_gnt", 64'(gnt), 64'd1);
      check("rd_setup", 64'({psel, penable}), 64'b10);
      check("rd_paddr", 64'(paddr), 64'h40);
      e.owner = 0; e.err = 1'b0; e.rdata = 32'hDEADBEEF;
      exp_q.push_back(e);
      req[0] = 1'b0;
      @(negedge pclk);
      check("rd_access", 64'({psel, penable}), 64'b11);
      pready = 1'b1; prdata = 32'hDEADBEEF;
      @(negedge pclk);
      check("rd_done_cycle", 64'(done), 64'd1);
      check("rd_idle", 64'(psel), 64'd0);
      pready = 1'b0;
      ref_ptr = 0; ref_rdata = 32'hDEADBEEF; prev_idle = 1'b1;

      // Randomized traffic.
      rnd_on = 1'b1;
      repeat (3000) @(negedge pclk) stim_step();
      rnd_on = 1'b0;
      drained = 1'b0;
      for (int c = 0; c < 3000 && !drained; c++) begin
         @(negedge pclk) stim_step();
         drained = (req == '0) && (exp_q.size() == 0) && !in_acc && !psel;
      end
      check("drain", 64'(drained), 64'd1);
      pready = 1'b0;
      repeat (2) @(negedge pclk);

      // Write held in wait states, then reset mid-ACCESS.
      req[2] = 1'b1; req_write[2] = DIR_WRITE;
      req_addr[2*AW +: AW] = 32'h10; req_wdata[2*DW +: DW] = 32'h12345678;
      @(negedge pclk);
      check("wr_gnt", 64'(gnt), 64'b0100);
      req[2] = 1'b0;
      repeat (2) begin
         @(negedge pclk);
         check("wr_hold_addr", 64'(paddr), 64'h10);
         check("wr_hold_data", 64'(pwdata), 64'h12345678);
      end
      #2 presetn = 1'b0;
      #1;
      check("rst_mid_bus", 64'({psel, penable}), 64'd0);
      check("rst_mid_done", 64'(done), 64'd0);
      check("rst_mid_rdata", 64'(rdata), 64'd0);
      @(negedge pclk);
      presetn = 1'b1;
      req = '1; req_write[0] = DIR_READ; req_addr[0 +: AW] = 32'h0;
      @(negedge pclk);
      check("post_rst_gnt", 64'(gnt), 64'd1);
      check("post_rst_nodone", 64'(done), 64'd0);
      e.owner = 0; e.err = 1'b1; e.rdata = 32'hAAAA5555;
      exp_q.push_back(e);
      req = '0;
      @(negedge pclk);
      pready = 1'b1; pslverr = 1'b1; prdata = 32'hAAAA5555;
      @(negedge pclk);
      check("slverr_done", 64'(done), 64'd1);
      pready = 1'b0; pslverr = 1'b0;
      repeat (2) @(negedge pclk);
      check("final_queue", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
